// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receive front-end: synchronises the pad lines, deframes 11-bit
// frames, folds F0/E0 prefixes into flags and queues key events in a small FIFO.
module ps2_kbd_rx #(
    parameter int clk_freq        = 50000000,
    parameter int timeout_us      = 200,
    parameter int fifo_depth_log2 = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clkps2,
    input  logic       ps2_dat_in,
    input  logic       rd_en,
    output logic [7:0] ev_code,
    output logic       ev_brk,
    output logic       ev_ext,
    output logic       empty,
    output logic       overflow,
    output logic       parity_err,
    output logic       frame_err
);

    localparam int TMO_LIMIT = clk_freq / 1000000 * timeout_us;
    localparam int TMO_W     = $clog2(TMO_LIMIT + 1);
    localparam int DEPTH     = 1 << fifo_depth_log2;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ev_t;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    // ---------------------------------------------------------------- sync
    logic [2:0] clk_sync;
    logic [1:0] dat_sync;
    logic       fall;
    logic       din;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync <= '1;
            dat_sync <= '1;
        end else begin
            clk_sync <= {clk_sync[1:0], clkps2};
            dat_sync <= {dat_sync[0], ps2_dat_in};
        end
    end

    assign fall = clk_sync[2] & ~clk_sync[1];
    assign din  = dat_sync[1];

    // ---------------------------------------------------------------- deframer
    state_t           state, state_nxt;
    logic [2:0]       bitcnt, bitcnt_nxt;
    logic [7:0]       shreg, shreg_nxt;
    logic             par_bit, par_nxt;
    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_hit;
    logic             perr_nxt, ferr_nxt, clr_nxt, byte_vld_nxt;
    logic             byte_vld;

    assign tmo_hit = (state != IDLE) && (tmo_cnt == TMO_W'(TMO_LIMIT - 1));

    always_comb begin
        state_nxt    = state;
        bitcnt_nxt   = bitcnt;
        shreg_nxt    = shreg;
        par_nxt      = par_bit;
        perr_nxt     = 1'b0;
        ferr_nxt     = 1'b0;
        clr_nxt      = 1'b0;
        byte_vld_nxt = 1'b0;
        if (fall) begin
            case (state)
                IDLE: begin
                    if (!din) begin
                        state_nxt  = DATA;
                        bitcnt_nxt = 3'd0;
                    end else begin
                        ferr_nxt = 1'b1;
                        clr_nxt  = 1'b1;
                    end
                end
                DATA: begin
                    shreg_nxt  = {din, shreg[7:1]};
                    bitcnt_nxt = bitcnt + 3'd1;
                    if (bitcnt == 3'd7) state_nxt = PARITY;
                end
                PARITY: begin
                    par_nxt   = din;
                    state_nxt = STOP;
                end
                STOP: begin
                    state_nxt = IDLE;
                    if (!din) begin
                        ferr_nxt = 1'b1;
                        clr_nxt  = 1'b1;
                    end else if (^{shreg, par_bit} == 1'b0) begin
                        perr_nxt = 1'b1;
                        clr_nxt  = 1'b1;
                    end else begin
                        byte_vld_nxt = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end else if (tmo_hit) begin
            // Stalled frame: drop the partial byte but keep any pending prefix.
            state_nxt = IDLE;
            ferr_nxt  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            bitcnt     <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            tmo_cnt    <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            byte_vld   <= 1'b0;
        end else begin
            state      <= state_nxt;
            bitcnt     <= bitcnt_nxt;
            shreg      <= shreg_nxt;
            par_bit    <= par_nxt;
            tmo_cnt    <= (fall || state == IDLE) ? '0 : tmo_cnt + 1'b1;
            parity_err <= perr_nxt;
            frame_err  <= ferr_nxt;
            byte_vld   <= byte_vld_nxt;
        end
    end

    // ---------------------------------------------------------------- prefix fold
    // shreg is stable through the cycle after STOP, so it serves as the byte.
    logic brk_pend, ext_pend;
    logic is_f0, is_e0, push;
    ev_t  push_ev;

    assign is_f0   = (shreg == 8'hF0);
    assign is_e0   = (shreg == 8'hE0);
    assign push    = byte_vld & ~is_f0 & ~is_e0;
    assign push_ev = '{ext: ext_pend, brk: brk_pend, code: shreg};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            brk_pend <= 1'b0;
            ext_pend <= 1'b0;
        end else if (clr_nxt) begin
            brk_pend <= 1'b0;
            ext_pend <= 1'b0;
        end else if (byte_vld) begin
            if (is_f0) begin
                brk_pend <= 1'b1;
            end else if (is_e0) begin
                ext_pend <= 1'b1;
            end else begin
                brk_pend <= 1'b0;
                ext_pend <= 1'b0;
            end
        end
    end

    // ---------------------------------------------------------------- event FIFO
    ev_t                        mem [DEPTH];
    logic [fifo_depth_log2-1:0] wr_ptr, rd_ptr;
    logic [fifo_depth_log2:0]   count;
    logic                       full, pop, do_push;
    ev_t                        head;

    assign full    = (count == (fifo_depth_log2 + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign pop     = rd_en & ~empty;
    assign do_push = push & (~full | pop);
    assign head    = mem[rd_ptr];
    assign ev_code = head.code;
    assign ev_brk  = head.brk;
    assign ev_ext  = head.ext;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_ev;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !pop)      count <= count + 1'b1;
            else if (!do_push && pop) count <= count - 1'b1;
            if (push && full && !pop) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Scoreboard bench for ps2_kbd_rx: stimulus queues expected events/errors,
// independent monitors pop and compare whenever the DUT presents them.
module tb_ps2_kbd_rx;

    localparam int HALF = 60;       // PS/2 half-period in system clocks
    localparam int TMO_LAT = 10003; // 3 sync clocks + 10000-cycle limit

    typedef struct {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ev_t;

    typedef struct {
        bit is_frame;
        bit chk_cyc;
        int exp_cyc;
    } err_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clkps2 = 1'b1;
    logic       ps2_dat_in = 1'b1;
    logic       rd_en = 1'b0;
    logic [7:0] ev_code;
    logic       ev_brk, ev_ext, empty, overflow, parity_err, frame_err;

    ev_t  ev_q[$];
    err_t err_q[$];
    ev_t  mon_e;
    err_t mon_r;
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   last_fall = 0;
    bit   auto_pop = 1'b0;

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ps2_kbd_rx dut (
        .clk        (clk),
        .rst        (rst),
        .clkps2     (clkps2),
        .ps2_dat_in (ps2_dat_in),
        .rd_en      (rd_en),
        .ev_code    (ev_code),
        .ev_brk     (ev_brk),
        .ev_ext     (ev_ext),
        .empty      (empty),
        .overflow   (overflow),
        .parity_err (parity_err),
        .frame_err  (frame_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        return {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    endfunction

    task automatic ps2_bit(input logic b);
        ps2_dat_in = b;
        repeat (HALF) @(negedge clk);
        clkps2 = 1'b0;
        last_fall = cyc;
        repeat (HALF) @(negedge clk);
        clkps2 = 1'b1;
    endtask

    task automatic send_bits(input logic [10:0] frm, input int n);
        for (int i = 0; i < n; i++) ps2_bit(frm[i]);
        ps2_dat_in = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        send_bits(mk_frame(b, 1'b0, 1'b0), 11);
    endtask

    task automatic exp_ev(input logic ext, input logic brk, input logic [7:0] code);
        ev_t e;
        e.ext = ext; e.brk = brk; e.code = code;
        ev_q.push_back(e);
    endtask

    task automatic exp_err(input bit is_frame, input bit chk_cyc, input int exp_cyc);
        err_t r;
        r.is_frame = is_frame; r.chk_cyc = chk_cyc; r.exp_cyc = exp_cyc;
        err_q.push_back(r);
    endtask

    // event monitor: pops the head whenever one is shown and popping is enabled
    always @(negedge clk) begin
        if (rd_en) begin
            rd_en = 1'b0;
        end else if (auto_pop && rst && !empty) begin
            if (ev_q.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL unexpected_event: got %0h/%0b/%0b, expected none", ev_code, ev_brk, ev_ext);
            end else begin
                mon_e = ev_q.pop_front();
                check("event {ext,brk,code}", 32'({ev_ext, ev_brk, ev_code}),
                      32'({mon_e.ext, mon_e.brk, mon_e.code}));
            end
            rd_en = 1'b1;
        end
    end

    // error monitor: every pulse cycle must match the next expected error
    always @(negedge clk) begin
        if (rst && (parity_err || frame_err)) begin
            if (err_q.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL unexpected_error: got parity_err=%0b frame_err=%0b, expected none", parity_err, frame_err);
            end else begin
                mon_r = err_q.pop_front();
                check("error pulse {parity,frame}", 32'({parity_err, frame_err}),
                      32'({~mon_r.is_frame, mon_r.is_frame}));
                if (mon_r.chk_cyc) check("timeout cycle", 32'(cyc), 32'(mon_r.exp_cyc));
            end
        end
    end

    initial begin
        // reset values
        repeat (3) @(negedge clk);
        check("rst empty", 32'(empty), 32'd1);
        check("rst overflow", 32'(overflow), 32'd0);
        check("rst parity_err", 32'(parity_err), 32'd0);
        check("rst frame_err", 32'(frame_err), 32'd0);
        check("rst ev", 32'({ev_ext, ev_brk, ev_code}), 32'd0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // make code 0x1C; empty must drop within 4 clk of the stop fall
        exp_ev(1'b0, 1'b0, 8'h1C);
        send_bits(mk_frame(8'h1C, 1'b0, 1'b0), 10);
        repeat (HALF) @(negedge clk);
        clkps2 = 1'b0;
        repeat (4) @(negedge clk);
        check("empty after stop fall", 32'(empty), 32'd0);
        repeat (HALF - 4) @(negedge clk);
        clkps2 = 1'b1;
        repeat (HALF) @(negedge clk);
        auto_pop = 1'b1;

        // break / extended prefixes
        exp_ev(1'b0, 1'b1, 8'h1C);
        send(8'hF0); send(8'h1C);
        exp_ev(1'b1, 1'b1, 8'h75);
        exp_ev(1'b0, 1'b0, 8'h75);
        send(8'hE0); send(8'hF0); send(8'h75); send(8'h75);

        // parity and stop errors; FIFO stays empty
        exp_err(1'b0, 1'b0, 0);
        send_bits(mk_frame(8'h1C, 1'b1, 1'b0), 11);
        check("empty after parity err", 32'(empty), 32'd1);
        exp_err(1'b1, 1'b0, 0);
        send_bits(mk_frame(8'h1C, 1'b0, 1'b1), 11);
        check("empty after stop err", 32'(empty), 32'd1);

        // an errored frame drops a pending break prefix
        exp_err(1'b0, 1'b0, 0);
        exp_ev(1'b0, 1'b0, 8'h1B);
        send(8'hF0);
        send_bits(mk_frame(8'h44, 1'b1, 1'b0), 11);
        send(8'h1B);

        // timeout after start + 4 data bits, then a clean frame
        send_bits(mk_frame(8'h5A, 1'b0, 1'b0), 5);
        exp_err(1'b1, 1'b1, last_fall + TMO_LAT);
        repeat (12500 - 2 * HALF) @(negedge clk);
        check("timeout consumed", 32'(err_q.size()), 32'd0);
        exp_ev(1'b0, 1'b0, 8'h32);
        send(8'h32);
        repeat (10) @(negedge clk);

        // overflow: five events, no pops
        auto_pop = 1'b0;
        exp_ev(1'b0, 1'b0, 8'h15);
        exp_ev(1'b0, 1'b0, 8'h1D);
        exp_ev(1'b0, 1'b0, 8'h24);
        exp_ev(1'b0, 1'b0, 8'h2D);
        send(8'h15); send(8'h1D); send(8'h24); send(8'h2D);
        check("overflow before 5th", 32'(overflow), 32'd0);
        send(8'h2C);
        repeat (10) @(negedge clk);
        check("overflow set", 32'(overflow), 32'd1);
        check("head after overflow", 32'(ev_code), 32'h15);
        auto_pop = 1'b1;
        repeat (20) @(negedge clk);
        check("empty after drain", 32'(empty), 32'd1);
        check("events outstanding", 32'(ev_q.size()), 32'd0);
        check("overflow sticky", 32'(overflow), 32'd1);

        // asynchronous reset in the middle of a frame
        send_bits(mk_frame(8'h3C, 1'b0, 1'b0), 5);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid rst empty", 32'(empty), 32'd1);
        check("mid rst overflow", 32'(overflow), 32'd0);
        check("mid rst errs", 32'({parity_err, frame_err}), 32'd0);
        check("mid rst ev", 32'({ev_ext, ev_brk, ev_code}), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // a clean frame after reset still works
        exp_ev(1'b0, 1'b0, 8'h4B);
        send(8'h4B);
        repeat (50) @(negedge clk);
        check("final events outstanding", 32'(ev_q.size()), 32'd0);
        check("final errors outstanding", 32'(err_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
